// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
// Shares one single-port VRAM between GPU scan-out and a CPU port.
// GPU owns memory on cycles where gpu_visible & gpu_slot; all other cycles are
// CPU slots. CPU writes are posted through a small FIFO. A CPU read waits until
// the FIFO has drained so it always observes earlier writes.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   gpu_addr/visible/slot, gpu_pixel      scan-out request and registered byte
//   cpu_wr/cpu_wr_ready/cpu_addr/cpu_wdata posted write handshake
//   cpu_rd/cpu_rd_busy/cpu_rdata/cpu_rvalid read request and completion
//   fifo_count          number of buffered writes
//   mem_addr/mem_wdata/mem_we/mem_rdata   VRAM port (read data combinational)
// -----------------------------------------------------------------------------
module vram_arbiter #(
   parameter int ADDR_BITS  = 15,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [ADDR_BITS-1:0]          gpu_addr,
   input  logic                          gpu_visible,
   input  logic                          gpu_slot,
   output logic [7:0]                    gpu_pixel,
   input  logic                          cpu_wr,
   output logic                          cpu_wr_ready,
   input  logic [ADDR_BITS-1:0]          cpu_addr,
   input  logic [7:0]                    cpu_wdata,
   input  logic                          cpu_rd,
   output logic                          cpu_rd_busy,
   output logic [7:0]                    cpu_rdata,
   output logic                          cpu_rvalid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [ADDR_BITS-1:0]          mem_addr,
   output logic [7:0]                    mem_wdata,
   output logic                          mem_we,
   input  logic [7:0]                    mem_rdata
);

   localparam int PTR_BITS = $clog2(FIFO_DEPTH);
   localparam logic [PTR_BITS:0] DEPTH_CNT = (PTR_BITS+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} rd_state_e;

   rd_state_e               state_q, state_d;
   logic [ADDR_BITS-1:0]    rd_addr_q, rd_addr_d;
   logic [7:0]              rdata_q, rdata_d;
   logic [7:0]              pixel_q, pixel_d;
   logic [PTR_BITS-1:0]     head_q, tail_q;
   logic [PTR_BITS:0]       count_q, count_d;

   // Posted-write storage; small enough that the head is read combinationally.
   logic [ADDR_BITS-1:0]    fifo_addr_mem [FIFO_DEPTH];
   logic [7:0]              fifo_data_mem [FIFO_DEPTH];

   logic gpu_own;
   logic fifo_empty;
   logic push;
   logic pop;
   logic rd_sample;

   assign gpu_own      = gpu_visible & gpu_slot;
   assign fifo_empty   = (count_q == '0);
   assign cpu_rd_busy  = (state_q != IDLE);
   assign cpu_wr_ready = (count_q < DEPTH_CNT) & ~cpu_rd_busy;
   assign push         = cpu_wr & cpu_wr_ready;
   // Buffered writes take priority over a pending read on CPU slots; this is
   // what guarantees a read sees every write accepted before it.
   assign pop          = ~gpu_own & ~fifo_empty;

   assign cpu_rvalid   = (state_q == RD_DONE);
   assign cpu_rdata    = rdata_q;
   assign gpu_pixel    = pixel_q;
   assign fifo_count   = count_q;
   assign mem_we       = pop;

   // ---------------- VRAM port multiplexer ----------------
   always_comb begin
      mem_addr  = gpu_addr;
      mem_wdata = 8'h00;
      if (!gpu_own) begin
         if (pop) begin
            mem_addr  = fifo_addr_mem[head_q];
            mem_wdata = fifo_data_mem[head_q];
         end else if (rd_sample) begin
            mem_addr  = rd_addr_q;
         end
      end
   end

   // ---------------- Read FSM next state ----------------
   always_comb begin
      state_d   = state_q;
      rd_addr_d = rd_addr_q;
      rdata_d   = rdata_q;
      rd_sample = 1'b0;
      case (state_q)
         IDLE: begin
            if (cpu_rd) begin
               rd_addr_d = cpu_addr;
               state_d   = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (!gpu_own && fifo_empty) begin
               rd_sample = 1'b1;
               rdata_d   = mem_rdata;
               state_d   = RD_DONE;
            end
         end
         RD_DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- Scan-out pixel and FIFO count ----------------
   always_comb begin
      pixel_d = pixel_q;
      if (!gpu_visible) begin
         pixel_d = 8'h00;
      end else if (gpu_slot) begin
         pixel_d = mem_rdata;
      end
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // ---------------- State registers ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         rd_addr_q <= '0;
         rdata_q   <= 8'h00;
         pixel_q   <= 8'h00;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         rd_addr_q <= rd_addr_d;
         rdata_q   <= rdata_d;
         pixel_q   <= pixel_d;
         count_q   <= count_d;
         // Pointers are exactly PTR_BITS wide, so they wrap modulo the depth.
         if (push) tail_q <= tail_q + PTR_BITS'(1);
         if (pop)  head_q <= head_q + PTR_BITS'(1);
      end
   end

   // Storage needs no reset: entries are only read once counted as valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr_mem[tail_q] <= cpu_addr;
         fifo_data_mem[tail_q] <= cpu_wdata;
      end
   end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter ADDR_BITS, default 15, VRAM address width (32 KiB).
REQ-002 Parameter FIFO_DEPTH, default 4, posted-write buffer entries (power of 2, >=2).
REQ-003 clk  input  1  system/pixel clock; all state on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 gpu_addr  input  ADDR_BITS  scan-out pixel address from the GPU timing block.
REQ-006 gpu_visible  input  1  GPU in active display region.
REQ-007 gpu_slot  input  1  high on cycles the GPU owns memory (even horizontal count).
REQ-008 gpu_pixel  output  8  registered scan-out byte to the GPU colour path.
REQ-009 cpu_wr  input  1  CPU write request (valid).
REQ-010 cpu_wr_ready  output  1  write buffer can accept.
REQ-011 cpu_addr  input  ADDR_BITS  CPU address, shared by reads and writes.
REQ-012 cpu_wdata  input  8  CPU write data.
REQ-013 cpu_rd  input  1  CPU read request, one-cycle pulse.
REQ-014 cpu_rd_busy  output  1  read outstanding.
REQ-015 cpu_rdata  output  8  read data, valid with cpu_rvalid.
REQ-016 cpu_rvalid  output  1  one-cycle read-complete pulse.
REQ-017 fifo_count  output  log2(FIFO_DEPTH)+1  buffered write count.
REQ-018 mem_addr  output  ADDR_BITS  VRAM address.
REQ-019 mem_wdata  output  8  VRAM write data.
REQ-020 mem_we  output  1  VRAM write enable, one cycle per write.
REQ-021 mem_rdata  input  8  VRAM read data, valid combinationally in the same cycle as mem_addr.

Function
REQ-022 Slot ownership: GPU slot = gpu_visible & gpu_slot; every other cycle is a CPU slot.
REQ-023 GPU slot: mem_addr = gpu_addr, mem_we = 0; gpu_pixel <= mem_rdata at that posedge (latency 1 cycle).
REQ-024 Any cycle with gpu_visible low: gpu_pixel <= 0x00; CPU slots never alter gpu_pixel.
REQ-025 Write buffer: FIFO of {addr, data}; push when cpu_wr & cpu_wr_ready; cpu_wr_ready = (fifo_count < FIFO_DEPTH) & ~cpu_rd_busy.
REQ-026 CPU slot with FIFO non-empty: mem_addr/mem_wdata = FIFO head, mem_we = 1, pop at that posedge.
REQ-027 Push and pop same cycle: fifo_count unchanged, head and tail pointers both advance; pointers wrap modulo FIFO_DEPTH.
REQ-028 cpu_wr while full or while a read is busy: ignored; no state change.
REQ-029 Read FSM states: IDLE, RD_WAIT, RD_DONE.
REQ-030 IDLE: cpu_rd -> latch cpu_addr, go RD_WAIT; cpu_rd_busy = 1 in RD_WAIT and RD_DONE.
REQ-031 RD_WAIT: on a CPU slot with FIFO empty, mem_addr = latched address, mem_we = 0, cpu_rdata <= mem_rdata, go RD_DONE.
REQ-032 RD_DONE: cpu_rvalid = 1 for exactly this cycle, go IDLE; cpu_rdata holds until next read.
REQ-033 Ordering: writes accepted before a read always reach VRAM before that read samples.
REQ-034 cpu_rd while busy: ignored.
REQ-035 Idle CPU slot (no write, no read): mem_we = 0, mem_addr = gpu_addr.
REQ-036 mem_we never asserted on a GPU slot; at most one VRAM access per cycle.
REQ-037 With gpu_slot toggling, CPU worst-case service rate = one access per 2 cycles during visible, one per cycle in blanking.

Reset
REQ-038 rst low forces immediately: FSM IDLE, FIFO empty, fifo_count 0, gpu_pixel 0x00, cpu_rdata 0x00, cpu_rvalid 0, cpu_rd_busy 0, mem_we 0.
REQ-039 Reset mid-operation discards buffered writes and any outstanding read; no completion pulse issued.
REQ-040 After rst rises, first posedge operates normally; cpu_wr_ready = 1.

Verification
REQ-041 Blanking (gpu_visible 0): 4 back-to-back writes 0x0000..0x0003 = 0x11..0x44 -> mem_we 1 on 4 consecutive cycles, fifo_count peaks <=1, returns 0.
REQ-042 Visible, gpu_slot toggling, 6 back-to-back writes -> FIFO fills to 4, cpu_wr_ready drops, writes issue only on gpu_slot=0 cycles, all 6 land in order.
REQ-043 Write 0x1234=0xA5 then cpu_rd 0x1234 next cycle -> rvalid after write completes, cpu_rdata 0xA5.
REQ-044 Visible, VRAM preloaded 0x7F at gpu_addr 0x0102, gpu_slot=1 -> gpu_pixel 0x7F next cycle; gpu_visible 0 -> gpu_pixel 0x00.
REQ-045 Fill FIFO with 3 writes, pull rst low mid-drain -> all outputs at reset values immediately, remaining writes never appear on mem_we.
REQ-046 cpu_rd during RD_WAIT and cpu_wr while full -> both ignored; exactly one rvalid pulse, fifo_count never exceeds 4.
